// File: rtl/gpi_pkg.sv
// Shared constants and types for the GPI input conditioner.
package gpi_pkg;

   localparam int unsigned GPI_WIDTH            = 8;
   localparam int unsigned GPI_DEBOUNCE_DEFAULT = 16;

   typedef logic [GPI_WIDTH-1:0] gpi_vec_t;

   // Debounce counter width: $clog2(n), but never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// Single-bit two-flop synchroniser plus debounce counter and stable level.
// s_d is only generated when GPI_COND_EDGE_IRQ_EN is defined.
module gpi_debounce_bit
   import gpi_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic s,
   output logic s_d
);

   localparam int unsigned           CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]         CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] c;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         s     <= 1'b0;
         c     <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // Any return to the stable level restarts the count.
         if (sync2 == s) begin
            c <= '0;
         end else if (c == CNT_MAX) begin
            s <= sync2;
            c <= '0;
         end else begin
            c <= c + 1'b1;
         end
      end
   end

`ifdef GPI_COND_EDGE_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) s_d <= 1'b0;
      else     s_d <= s;
   end
`else
   assign s_d = 1'b0;
`endif

endmodule

// File: rtl/gpi_input_conditioner.sv
// Synchronise, debounce and edge-detect GPI pad inputs; optional sticky
// edge pending flags and irq when GPI_COND_EDGE_IRQ_EN is defined.
module gpi_input_conditioner
   import gpi_pkg::*;
#(
   parameter int unsigned WIDTH           = GPI_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic [WIDTH-1:0] inport_raw,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] pend_clr,
   output logic [WIDTH-1:0] inport_clean,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic [WIDTH-1:0] pending,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpi_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk (PCLK),
         .rst (PRESET),
         .raw (inport_raw[i]),
         .s   (stable[i]),
         .s_d (stable_d[i])
      );
   end

   assign inport_clean = stable;

`ifdef GPI_COND_EDGE_IRQ_EN
   assign rise_o = stable & ~stable_d;
   assign fall_o = ~stable & stable_d;

   // A new edge event overrides a same-cycle clear.
   always_ff @(posedge PCLK) begin
      if (PRESET) pending <= '0;
      else        pending <= (pending & ~pend_clr) | (rise_o & rise_en) | (fall_o & fall_en);
   end

   assign irq = |pending;
`else
   logic unused_edge_inputs;

   assign rise_o  = '0;
   assign fall_o  = '0;
   assign pending = '0;
   assign irq     = 1'b0;
   assign unused_edge_inputs = ^{rise_en, fall_en, pend_clr, stable_d};
`endif

endmodule

// File: doc/gpi_input_conditioner.md
# gpi_input_conditioner

Per-bit input conditioner that sits directly upstream of the GPI peripheral: it takes raw, asynchronous pad levels, synchronises and debounces them, and drives the clean levels into the GPI `inport`. It also detects rising and falling edges of the debounced levels and latches them into a sticky pending register that raises a single level-sensitive interrupt line toward the interrupt controller.

## Interface
- `WIDTH`, default 8: number of input bits; matches the GPI `inport` width.
- `DEBOUNCE_CYCLES`, default 16: consecutive `PCLK` cycles a new level must hold before it is accepted; legal range ≥ 1.
- `PCLK`, input, 1: the only clock; all state is on its rising edge.
- `PRESET`, input, 1: reset, synchronous and active-high.
- `inport_raw`, input, WIDTH: asynchronous pad levels.
- `rise_en`, input, WIDTH: per-bit enable for latching a rising edge into `pending`.
- `fall_en`, input, WIDTH: per-bit enable for latching a falling edge into `pending`.
- `pend_clr`, input, WIDTH: per-bit write-1-to-clear strobe for `pending`.
- `inport_clean`, output, WIDTH: debounced levels; connects to the GPI `inport`.
- `rise_o`, output, WIDTH: one-cycle pulse on a debounced 0→1 transition.
- `fall_o`, output, WIDTH: one-cycle pulse on a debounced 1→0 transition.
- `pending`, output, WIDTH: sticky edge-event flags.
- `irq`, output, 1: OR-reduction of `pending`.

## Operation
- Synchroniser: per bit, `sync1 <= inport_raw`, then `sync2 <= sync1`. Both reset to 0.
- Debounce, per bit, with stable level `s` (reset 0) and counter `c` (reset 0, width `$clog2(DEBOUNCE_CYCLES)`, minimum 1):
  - If `sync2 == s`: `c <= 0`.
  - Else if `c == DEBOUNCE_CYCLES-1`: `s <= sync2`, `c <= 0`.
  - Else: `c <= c+1`.
  - Any return of `sync2` to `s` before acceptance restarts the count from 0. Bits are independent.
- `inport_clean = s`, driven directly from a register.
- Edge detect, with `s_d` as `s` delayed by one register (reset 0):
  - `rise_o = s & ~s_d`
  - `fall_o = ~s & s_d`
- Pending register, per bit: `pending <= (pending & ~pend_clr) | (rise_o & rise_en) | (fall_o & fall_en)`.
  - If a set and a clear arrive in the same cycle, the set wins.
  - `pending` stays set until cleared. Disabling an enable does not clear an existing flag.
- `irq = |pending`, combinational from registered `pending`.

## Timing
- All outputs are 0 during reset and in the cycle after `PRESET` deasserts.
- Reset asserted mid-count discards the count; `s`, `c`, sync flops, `s_d`, and `pending` all return to 0 at that edge.
- Latency, with raw level change first sampled at edge E0:
  - `sync2` is new after E0+1.
  - `inport_clean` changes after edge E0+DEBOUNCE_CYCLES+1.
  - `rise_o`/`fall_o` is high for exactly the cycle following that edge.
  - `pending` sets on the next edge.
  - `irq` follows `pending` in the same cycle.
- A pulse on `sync2` shorter than `DEBOUNCE_CYCLES` cycles produces no change on any output.
- Edge pulses never exceed one cycle.
- Back-to-back accepted edges are separated by at least `DEBOUNCE_CYCLES` cycles.
- The counter never wraps: it saturates at acceptance and is then reset to 0.

## Configuration
- `GPI_COND_EDGE_IRQ_EN` defined: edge detect, `pending`, and `irq` are present as described above.
- `GPI_COND_EDGE_IRQ_EN` undefined:
  - `s_d` and `pending` logic are not generated.
  - `rise_o`, `fall_o`, `pending`, and `irq` are tied to 0.
  - `rise_en`, `fall_en`, and `pend_clr` are ignored.
  - Synchroniser and debounce behaviour are unchanged.

## Structure
- Shared package `gpi_pkg`:
  - `GPI_WIDTH = 8`
  - `GPI_DEBOUNCE_DEFAULT = 16`
  - typedef `gpi_vec_t` (`logic [GPI_WIDTH-1:0]`)
- One sub-module, `gpi_debounce_bit`: synchroniser, counter, and `s` for a single bit, with outputs `s` and `s_d`. The top instantiates it WIDTH times in a generate loop. The top holds `pending` and `irq`.

## Test plan
- Reset: drive `inport_raw=8'hFF` with `PRESET=1` for 3 cycles → every output is 0. After release with N=4, `inport_clean` reaches 8'hFF 6 edges after the first sample.
- Clean transition, N=4: bit 0 goes 0→1 and holds → `inport_clean[0]` rises after edge E0+5; `rise_o[0]` is high for 1 cycle; with `rise_en[0]=1`, `pending[0]=1` and `irq=1`.
- Glitch rejection, N=4: bit 3 is high for 3 cycles, then low → `inport_clean`, `rise_o`, and `pending` stay 0. A later 4-cycle high is accepted.
- Simultaneous set/clear: `pend_clr[2]=1` in the same cycle that `fall_o[2]` and `fall_en[2]` are 1 → `pending[2]` stays 1. Clear on the next cycle → 0; `irq` drops.
- Reset mid-count: assert `PRESET` while the bit 5 counter is at 2 → counter, `s`, and outputs are 0. After release, a full N+2 edges are needed again.
- Macro undefined: repeat the clean transition test → `inport_clean` behaves identically; `rise_o`, `fall_o`, `pending`, and `irq` stay 0 throughout.
